// File: rtl/xillybus_loop_fifo_32_if.sv
// Xillybus 32-bit write/read stream pair between xillybus_core (master) and a user FIFO (slave).
interface xillybus_loop_fifo_32_if;
   logic        user_w_write_32_wren;
   logic [31:0] user_w_write_32_data;
   logic        user_w_write_32_full;
   logic        user_w_write_32_open;
   logic        user_r_read_32_rden;
   logic [31:0] user_r_read_32_data;
   logic        user_r_read_32_empty;
   logic        user_r_read_32_eof;
   logic        user_r_read_32_open;

   modport master (
      output user_w_write_32_wren, user_w_write_32_data, user_w_write_32_open,
      output user_r_read_32_rden, user_r_read_32_open,
      input  user_w_write_32_full, user_r_read_32_data,
      input  user_r_read_32_empty, user_r_read_32_eof
   );

   modport slave (
      input  user_w_write_32_wren, user_w_write_32_data, user_w_write_32_open,
      input  user_r_read_32_rden, user_r_read_32_open,
      output user_w_write_32_full, user_r_read_32_data,
      output user_r_read_32_empty, user_r_read_32_eof
   );
endinterface

// File: rtl/xillybus_loop_fifo_32.sv
// Host loopback FIFO: write stream words return in order on the read stream, 1-cycle read latency.
// Writes while full are dropped and counted; reads while empty are ignored; reader close flushes.
module xillybus_loop_fifo_32 #(
   parameter int DEPTH_LOG2 = 9
) (
   input  logic                   bus_clk,
   input  logic                   bus_rst,
   xillybus_loop_fifo_32_if.slave xb,
   output logic [DEPTH_LOG2:0]    fill_level,
   output logic [15:0]            drop_count
);
   localparam logic [DEPTH_LOG2:0] DEPTH_CNT = {1'b1, {DEPTH_LOG2{1'b0}}};

   logic [31:0]           mem [2**DEPTH_LOG2];
   logic [DEPTH_LOG2-1:0] wr_ptr;
   logic [DEPTH_LOG2-1:0] rd_ptr;
   logic [DEPTH_LOG2:0]   count;
   logic [31:0]           rd_data;
   logic                  wr_open_q;
   logic                  rd_open_q;
   logic                  wr_done;
   logic                  eof_q;

   logic full;
   logic empty;
   logic flush;
   logic wr_fall;
   logic wr_rise;
   logic wr_acc;
   logic rd_acc;
   logic wr_drop;

   assign full    = (count == DEPTH_CNT);
   assign empty   = (count == '0);
   assign flush   = rd_open_q & ~xb.user_r_read_32_open;
   assign wr_fall = wr_open_q & ~xb.user_w_write_32_open;
   assign wr_rise = ~wr_open_q & xb.user_w_write_32_open;
   // A reader close discards everything in flight, including a same-cycle write.
   assign wr_acc  = xb.user_w_write_32_wren & ~full & ~flush & ~bus_rst;
   assign rd_acc  = xb.user_r_read_32_rden & ~empty & ~flush;
   assign wr_drop = xb.user_w_write_32_wren & full & ~flush;

   always_ff @(posedge bus_clk) begin
      if (wr_acc)
         mem[wr_ptr] <= xb.user_w_write_32_data;
   end

   always_ff @(posedge bus_clk) begin
      if (bus_rst) begin
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         count      <= '0;
         rd_data    <= '0;
         wr_open_q  <= 1'b0;
         rd_open_q  <= 1'b0;
         wr_done    <= 1'b0;
         eof_q      <= 1'b0;
         drop_count <= '0;
      end else begin
         wr_open_q <= xb.user_w_write_32_open;
         rd_open_q <= xb.user_r_read_32_open;
         eof_q     <= wr_done & empty;

         if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
         end else begin
            if (wr_acc)
               wr_ptr <= wr_ptr + 1'b1;
            if (rd_acc) begin
               rd_ptr  <= rd_ptr + 1'b1;
               rd_data <= mem[rd_ptr];
            end
            case ({wr_acc, rd_acc})
               2'b10:   count <= count + 1'b1;
               2'b01:   count <= count - 1'b1;
               default: count <= count;
            endcase
         end

         if (flush || wr_rise)
            wr_done <= 1'b0;
         else if (wr_fall)
            wr_done <= 1'b1;

         if (wr_drop && drop_count != 16'hFFFF)
            drop_count <= drop_count + 1'b1;
      end
   end

   assign xb.user_w_write_32_full  = full;
   assign xb.user_r_read_32_empty  = empty;
   assign xb.user_r_read_32_data   = rd_data;
   assign xb.user_r_read_32_eof    = eof_q;
   assign fill_level               = count;
endmodule
